// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP32 divide back end (div_round_pack).
package fp_div_pkg;

   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   localparam logic [31:0] QNAN = 32'h7FC00000;
   localparam int          BIAS = 127;
   localparam int          EMAX = 255;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rnd_mode_e;

   typedef enum logic [2:0] {
      SP_NONE,
      SP_QNAN,
      SP_INVALID,
      SP_INF,
      SP_DZ,
      SP_ZERO
   } special_e;

   typedef struct packed {
      logic              sign;
      logic signed [9:0] e;
      logic [22:0]       man;
      logic              g;
      logic              s;
      special_e          kind;
      rnd_mode_e         rm;
   } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational mantissa rounder: applies the mode's increment to man/G/S and reports carry-out.
module fp_round_rne
   import fp_div_pkg::*;
(
   input  logic        i_sign,
   input  logic [22:0] i_man,
   input  logic        i_g,
   input  logic        i_s,
   input  rnd_mode_e   i_mode,
   output logic [22:0] o_man,
   output logic        o_carry
);

   logic w_inc;

   always_comb begin
      w_inc = i_g && (i_s || i_man[0]);
      case (i_mode)
         RM_RTZ:  w_inc = 1'b0;
         RM_RDN:  w_inc = i_sign && (i_g || i_s);
         RM_RUP:  w_inc = !i_sign && (i_g || i_s);
         RM_RMM:  w_inc = i_g;
         default: w_inc = i_g && (i_s || i_man[0]);
      endcase
   end

   assign {o_carry, o_man} = {1'b0, i_man} + {23'd0, w_inc};

endmodule

// File: rtl/div_round_pack.sv
// FP32 divide back end: classify/normalize, then round/pack; two-stage valid/ready pipe.
// Optional macro DIV_RM_EN adds the rnd_mode port; otherwise RNE only.
module div_round_pack
   import fp_div_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned QUO_W = 27
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef DIV_RM_EN
   input  logic [2:0]       rnd_mode,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [QUO_W-1:0] in_quo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [4:0]       out_flags
);

   logic [EXP_W-1:0] w_a_exp, w_b_exp;
   logic [22:0]      w_a_frac, w_b_frac;
   logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf;
   logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
   logic             w_shift;
   rnd_mode_e        w_rm;
   s1_t              w_s1_d;
   s1_t              r_s1;
   logic             r_s1_valid;
   logic             w_s1_adv, w_s2_adv;
   logic             r_out_valid;
   logic [31:0]      r_out_result;
   logic [4:0]       r_out_flags;

`ifdef DIV_RM_EN
   assign w_rm = (rnd_mode > 3'd4) ? RM_RNE : rnd_mode_e'(rnd_mode);
`else
   assign w_rm = RM_RNE;
`endif

   assign w_a_exp  = in_a[30:23];
   assign w_b_exp  = in_b[30:23];
   assign w_a_frac = in_a[22:0];
   assign w_b_frac = in_b[22:0];

   // Denormals have a zero exponent and are taken as zero.
   assign w_a_zero = (w_a_exp == '0);
   assign w_b_zero = (w_b_exp == '0);
   assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
   assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
   assign w_a_nan  = (&w_a_exp) && (|w_a_frac);
   assign w_b_nan  = (&w_b_exp) && (|w_b_frac);
   assign w_a_snan = w_a_nan && !w_a_frac[22];
   assign w_b_snan = w_b_nan && !w_b_frac[22];
   assign w_shift  = !in_quo[25];

   always_comb begin
      w_s1_d      = '0;
      w_s1_d.sign = in_a[31] ^ in_b[31];
      w_s1_d.rm   = w_rm;
      if (in_quo[25]) begin
         w_s1_d.man = in_quo[24:2];
         w_s1_d.g   = in_quo[1];
         w_s1_d.s   = in_quo[0];
      end else begin
         w_s1_d.man = in_quo[23:1];
         w_s1_d.g   = in_quo[0];
         w_s1_d.s   = 1'b0;
      end
      w_s1_d.e = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp})
                 + 10'(BIAS) - $signed({9'd0, w_shift});
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         if (w_a_snan || w_b_snan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_s1_d.kind = SP_INVALID;
         end else begin
            w_s1_d.kind = SP_QNAN;
         end
      end else if (w_a_inf) begin
         w_s1_d.kind = SP_INF;
      end else if (w_b_zero) begin
         w_s1_d.kind = SP_DZ;
      end else if (w_a_zero || w_b_inf) begin
         w_s1_d.kind = SP_ZERO;
      end else begin
         w_s1_d.kind = SP_NONE;
      end
   end

   assign w_s2_adv = !r_out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1 <= w_s1_d;
         end
      end
   end

   logic [22:0]       w_man_rnd;
   logic              w_carry;
   logic signed [9:0] w_e_rnd;
   logic              w_to_max;
   logic [31:0]       w_res;
   logic [4:0]        w_flags;

   fp_round_rne u_round (
      .i_sign  (r_s1.sign),
      .i_man   (r_s1.man),
      .i_g     (r_s1.g),
      .i_s     (r_s1.s),
      .i_mode  (r_s1.rm),
      .o_man   (w_man_rnd),
      .o_carry (w_carry)
   );

   assign w_e_rnd  = $signed(r_s1.e) + $signed({9'd0, w_carry});
   // Modes rounding toward the finite side saturate at max-finite on overflow.
   assign w_to_max = (r_s1.rm == RM_RTZ) || ((r_s1.rm == RM_RDN) && !r_s1.sign)
                     || ((r_s1.rm == RM_RUP) && r_s1.sign);

   always_comb begin
      w_res   = '0;
      w_flags = '0;
      case (r_s1.kind)
         SP_QNAN: w_res = QNAN;
         SP_INVALID: begin
            w_res            = QNAN;
            w_flags[FLAG_NV] = 1'b1;
         end
         SP_INF:  w_res = {r_s1.sign, 8'hFF, 23'd0};
         SP_DZ: begin
            w_res            = {r_s1.sign, 8'hFF, 23'd0};
            w_flags[FLAG_DZ] = 1'b1;
         end
         SP_ZERO: w_res = {r_s1.sign, 31'd0};
         default: begin
            if (w_e_rnd >= 10'(EMAX)) begin
               w_res            = w_to_max ? {r_s1.sign, 31'h7F7FFFFF} : {r_s1.sign, 8'hFF, 23'd0};
               w_flags[FLAG_OF] = 1'b1;
               w_flags[FLAG_NX] = 1'b1;
            end else if (w_e_rnd <= 10'sd0) begin
               w_res            = {r_s1.sign, 31'd0};
               w_flags[FLAG_UF] = 1'b1;
               w_flags[FLAG_NX] = 1'b1;
            end else begin
               w_res            = {r_s1.sign, w_e_rnd[7:0], w_man_rnd};
               w_flags[FLAG_NX] = r_s1.g || r_s1.s;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_flags  <= '0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_result <= w_res;
            r_out_flags  <= w_flags;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_flags  = r_out_flags;

`ifndef SYNTHESIS
   // Non-special operands must carry a quotient in [0.5, 2).
   a_quo_range : assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && in_ready && (w_s1_d.kind == SP_NONE))
      |-> (!in_quo[26] && (in_quo[25:24] != 2'b00)));
`endif

endmodule

// File: tb/tb_div_round_pack.sv
// Self-checking bench for div_round_pack: directed cases, backpressure, reset, random vs. model.
module tb_div_round_pack;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [26:0] q;
      logic [36:0] exp;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic [26:0] in_quo;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_flags;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   int unsigned n_acc   = 0;
   op_t         stim_q[$];
   logic [36:0] exp_q[$];
   op_t         cur;
   logic        sent = 1'b0;
   logic        hold = 1'b0;
   logic [36:0] held;

   always #5 clk = ~clk;

   div_round_pack u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef DIV_RM_EN
      .rnd_mode   (3'd0),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_quo     (in_quo),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: IEEE classification plus integer rounding of the quotient value.
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [26:0] q);
      int          ea, eb, e;
      int unsigned fa, fb, qv, keep, rem;
      logic        sgn, az, bz, ai, bi, an, bn, asn, bsn;
      logic [4:0]  fl;
      logic [31:0] r;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      fa  = a[22:0];
      fb  = b[22:0];
      sgn = a[31] ^ b[31];
      az  = (ea == 0);
      bz  = (eb == 0);
      ai  = (ea == 255) && (fa == 0);
      bi  = (eb == 255) && (fb == 0);
      an  = (ea == 255) && (fa != 0);
      bn  = (eb == 255) && (fb != 0);
      asn = an && (fa < 32'h400000);
      bsn = bn && (fb < 32'h400000);
      fl  = 5'b0;
      if (an || bn || (az && bz) || (ai && bi)) begin
         r     = 32'h7FC00000;
         fl[4] = asn || bsn || (az && bz) || (ai && bi);
      end else if (ai) begin
         r = {sgn, 8'hFF, 23'h0};
      end else if (bz) begin
         r     = {sgn, 8'hFF, 23'h0};
         fl[3] = 1'b1;
      end else if (az || bi) begin
         r = {sgn, 31'h0};
      end else begin
         e  = ea - eb + 127;
         qv = q;
         if (qv >= 32'h2000000) begin
            keep = qv / 4;
            rem  = qv % 4;
         end else begin
            keep = qv / 2;
            rem  = (qv % 2) * 2;
            e    = e - 1;
         end
         if (rem > 2 || (rem == 2 && (keep % 2) == 1)) keep = keep + 1;
         if (keep >= 32'h1000000) begin
            keep = keep / 2;
            e    = e + 1;
         end
         if (e >= 255) begin
            r  = {sgn, 8'hFF, 23'h0};
            fl = 5'b00101;
         end else if (e <= 0) begin
            r  = {sgn, 31'h0};
            fl = 5'b00011;
         end else begin
            r     = {sgn, 8'(e), 23'(keep)};
            fl[0] = (rem != 0);
         end
      end
      return {fl, r};
   endfunction

   function automatic logic [31:0] rand_fp();
      int unsigned k;
      logic        s;
      k = $urandom_range(99);
      s = 1'($urandom_range(1));
      if (k < 6)       return {s, 31'h0};
      else if (k < 9)  return {s, 8'h00, 23'($urandom_range(32'h7FFFFF, 1))};
      else if (k < 13) return {s, 8'hFF, 23'h0};
      else if (k < 15) return {s, 8'hFF, 1'b1, 22'($urandom)};
      else if (k < 17) return {s, 8'hFF, 1'b0, 22'($urandom_range(32'h3FFFFF, 1))};
      else if (k < 40) return {s, 8'($urandom_range(254, 1)), 23'($urandom)};
      else             return {s, 8'($urandom_range(150, 104)), 23'($urandom)};
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.a   = rand_fp();
      o.b   = rand_fp();
      o.q   = 27'($urandom_range(32'h3FFFFFF, 32'h1000000));
      o.exp = model(o.a, o.b, o.q);
      return o;
   endfunction

   function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [26:0] q,
                              input logic [31:0] r, input logic [4:0] f);
      op_t o;
      o.a   = a;
      o.b   = b;
      o.q   = q;
      o.exp = {f, r};
      return o;
   endfunction

   // One clock: present stimulus at the falling edge, predict both handshakes just after.
   task automatic cycle(input int unsigned pv, input int unsigned pr);
      logic [36:0] e;
      @(negedge clk);
      if (sent) begin
         in_valid = 1'b0;
         sent     = 1'b0;
      end
      if (!in_valid && stim_q.size() != 0 && $urandom_range(99) < pv) begin
         cur      = stim_q.pop_front();
         in_a     = cur.a;
         in_b     = cur.b;
         in_quo   = cur.q;
         in_valid = 1'b1;
      end
      out_ready = ($urandom_range(99) < pr);
      #1;
      if (hold) check_eq("hold_stable", {out_valid, out_flags, out_result}, {1'b1, held});
      hold = out_valid && !out_ready;
      held = {out_flags, out_result};
      if (out_valid && out_ready) begin
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else e = '1;
         check_eq("result", {out_flags, out_result}, e);
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(cur.exp);
         sent = 1'b1;
         n_acc++;
      end
   endtask

   task automatic drain(input int unsigned pv, input int unsigned pr, input int unsigned budget);
      int unsigned n = 0;
      while ((stim_q.size() != 0 || in_valid || exp_q.size() != 0) && n < budget) begin
         cycle(pv, pr);
         n++;
      end
      check_eq("drain_done", stim_q.size() + exp_q.size(), 0);
   endtask

   initial begin
      int unsigned base;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_quo    = '0;
      out_ready = 1'b0;
      #12;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_result", out_result, 0);
      check_eq("rst_out_flags", out_flags, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_in_ready", in_ready, 1);

      // Latency: accepted at one edge, visible two edges later.
      @(negedge clk);
      in_a = 32'h40400000; in_b = 32'h3F800000; in_quo = 27'h3000000;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("lat_cycle1", out_valid, 0);
      @(negedge clk);
      check_eq("lat_cycle2", out_valid, 1);
      check_eq("lat_result", out_result, 32'h40400000);
      check_eq("lat_flags", out_flags, 0);
      @(negedge clk);

      stim_q.push_back(mk(32'h3F800000, 32'h40400000, 27'h1555555, 32'h3EAAAAAA, 5'b00001));
      stim_q.push_back(mk(32'h3F800000, 32'h3F800000, 27'h3FFFFFF, 32'h40000000, 5'b00001));
      stim_q.push_back(mk(32'h3F800000, 32'h00000000, 27'h0, 32'h7F800000, 5'b01000));
      stim_q.push_back(mk(32'h00000000, 32'h00000000, 27'h0, 32'h7FC00000, 5'b10000));
      stim_q.push_back(mk(32'h7F000000, 32'h00800000, 27'h2000000, 32'h7F800000, 5'b00101));
      stim_q.push_back(mk(32'h00800000, 32'h7F000000, 27'h2000000, 32'h00000000, 5'b00011));
      stim_q.push_back(mk(32'hC0400000, 32'h3F800000, 27'h3000000, 32'hC0400000, 5'b00000));
      stim_q.push_back(mk(32'h7F800001, 32'h3F800000, 27'h0, 32'h7FC00000, 5'b10000));
      stim_q.push_back(mk(32'h7FC00001, 32'h3F800000, 27'h0, 32'h7FC00000, 5'b00000));
      stim_q.push_back(mk(32'h7F800000, 32'hFF800000, 27'h0, 32'h7FC00000, 5'b10000));
      stim_q.push_back(mk(32'hFF800000, 32'h40000000, 27'h0, 32'hFF800000, 5'b00000));
      stim_q.push_back(mk(32'h00000000, 32'hC0000000, 27'h0, 32'h80000000, 5'b00000));
      stim_q.push_back(mk(32'h40000000, 32'h7F800000, 27'h0, 32'h00000000, 5'b00000));
      stim_q.push_back(mk(32'h00000001, 32'h3F800000, 27'h2000000, 32'h00000000, 5'b00000));
      stim_q.push_back(mk(32'hBF800000, 32'h00000001, 27'h2000000, 32'hFF800000, 5'b01000));
      stim_q.push_back(mk(32'h00000001, 32'h80000005, 27'h0, 32'h7FC00000, 5'b10000));
      drain(100, 100, 100);

      // Backpressure: two ops fill the pipe, the third waits.
      base = n_acc;
      repeat (3) stim_q.push_back(rand_op());
      repeat (6) cycle(100, 0);
      check_eq("bp_accepted", n_acc - base, 2);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      drain(100, 100, 50);

      // Reset mid-flight discards everything in the pipe.
      repeat (3) stim_q.push_back(rand_op());
      repeat (2) cycle(100, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_out_result", out_result, 0);
      check_eq("midrst_out_flags", out_flags, 0);
      stim_q.delete();
      exp_q.delete();
      in_valid = 1'b0;
      sent     = 1'b0;
      hold     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("midrst_in_ready", in_ready, 1);
      repeat (8) begin
         cycle(0, 100);
         check_eq("midrst_quiet", out_valid, 0);
      end

      repeat (400) stim_q.push_back(rand_op());
      drain(80, 70, 10000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
